// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encoding,
// default line address/data widths and the requester side encoding.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC_I  = 3'd1,
    ST_ACC_D  = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker between the I-side and D-side requests.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When defined, a tie goes to
// the side named by i_prio (the side not served last); otherwise D always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_ic,
  input  logic i_req_dc,
  input  logic i_prio,
  output logic o_side,
  output logic o_valid
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the pointer; keep it visibly consumed.
  logic w_unused_prio;
  assign w_unused_prio = i_prio;
`endif

  // Select the winning side among the pending requests.
  always_comb begin
    o_valid = i_req_ic | i_req_dc;
    o_side  = SIDE_D;
    if (i_req_ic && i_req_dc) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      o_side = i_prio;
`else
      o_side = SIDE_D;
`endif
    end else if (i_req_ic) begin
      o_side = SIDE_I;
    end else begin
      o_side = SIDE_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory line port between the I-cache refill path and the
// D-cache refill/write-back path. One transaction at a time; all outputs are
// registered. Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on
// simultaneous requests instead of fixed D-side priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
  logic              r_i_ready, w_i_ready_nxt;
  logic              r_d_ready, w_d_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_prio;
  logic              w_pick_side;
  logic              w_pick_valid;
  logic              w_grant;

  mem_arb_pick u_pick (
    .i_req_ic (i_req),
    .i_req_dc (d_req),
    .i_prio   (w_prio),
    .o_side   (w_pick_side),
    .o_valid  (w_pick_valid)
  );

  assign w_grant = (r_state == ST_IDLE) && w_pick_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_prio;

  // Round-robin pointer: after each grant the other side is favoured on a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= SIDE_D;
    end else if (w_grant) begin
      r_prio <= ~w_pick_side;
    end else begin
      r_prio <= r_prio;
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = SIDE_D;
`endif

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_i_rdata_nxt   = r_i_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_i_ready_nxt   = 1'b0;
    w_d_ready_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant && (w_pick_side == SIDE_I)) begin
          w_mem_addr_nxt  = i_addr;
          w_mem_read_nxt  = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = ST_ACC_I;
        end else if (w_grant) begin
          w_mem_addr_nxt  = d_addr;
          w_mem_wdata_nxt = d_wdata;
          w_mem_read_nxt  = ~d_wen;
          w_mem_write_nxt = d_wen;
          w_state_nxt     = ST_ACC_D;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACC_I: begin
        if (mem_ready) begin
          w_mem_read_nxt = 1'b0;
          w_i_rdata_nxt  = mem_rdata;
          w_i_ready_nxt  = 1'b1;
          w_state_nxt    = ST_RESP_I;
        end else begin
          w_state_nxt = ST_ACC_I;
        end
      end
      ST_ACC_D: begin
        if (mem_ready) begin
          // Write-backs return no data, so d_rdata keeps its previous line.
          if (r_mem_read) begin
            w_d_rdata_nxt = mem_rdata;
          end else begin
            w_d_rdata_nxt = r_d_rdata;
          end
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_d_ready_nxt   = 1'b1;
          w_state_nxt     = ST_RESP_D;
        end else begin
          w_state_nxt = ST_ACC_D;
        end
      end
      ST_RESP_I: w_state_nxt = ST_IDLE;
      ST_RESP_D: w_state_nxt = ST_IDLE;
      default: begin
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_i_ready   <= w_i_ready_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized request mixes, checked against a transaction-level model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req;
  logic [27:0]  i_addr;
  logic [127:0] i_rdata;
  logic         i_ready;
  logic         d_req;
  logic         d_wen;
  logic [27:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: last line returned to each side and tie-break side.
  logic [127:0] m_i_rdata;
  logic [127:0] m_d_rdata;
  logic         m_prio;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [27:0] rand28();
    logic [31:0] v;
    v = $urandom;
    return v[27:0];
  endfunction

  // One complete transaction from the current IDLE cycle: grant, lat cycles
  // of access (mem_ready on the last), response pulse, return to IDLE.
  task automatic serve(input int lat, input bit raise_d, input logic [127:0] rd);
    logic        side;
    logic        wr;
    logic [27:0] a;
    logic [127:0] wd;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      side = m_prio;
`else
      side = 1'b1;
`endif
    end else begin
      side = d_req;
    end
    m_prio = ~side;
    wr = side & d_wen;
    a  = side ? d_addr : i_addr;
    wd = d_wdata;

    step();
    chk("grant_read", mem_read, !wr);
    chk("grant_write", mem_write, wr);
    chk("grant_addr", mem_addr, a);
    if (wr) chk("grant_wdata", mem_wdata, wd);
    chk("grant_busy", busy, 1);
    chk("grant_no_ready", {i_ready, d_ready}, 0);

    if (raise_d) begin
      d_req   = 1'b1;
      d_wen   = 1'($urandom_range(0, 1));
      d_addr  = rand28();
      d_wdata = rand128();
    end

    for (int k = 1; k < lat; k++) begin
      step();
      chk("hold_read", mem_read, !wr);
      chk("hold_write", mem_write, wr);
      chk("hold_addr", mem_addr, a);
      chk("hold_no_ready", {i_ready, d_ready}, 0);
    end

    mem_rdata = rd;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_rdata = rand128();
    if (!side) m_i_rdata = rd;
    else if (!wr) m_d_rdata = rd;
    chk("resp_i_ready", i_ready, !side);
    chk("resp_d_ready", d_ready, side);
    chk("resp_i_rdata", i_rdata, m_i_rdata);
    chk("resp_d_rdata", d_rdata, m_d_rdata);
    chk("resp_strobes", {mem_read, mem_write}, 0);
    chk("resp_addr_kept", mem_addr, a);
    chk("resp_busy", busy, 1);

    if (!side) i_req = 1'b0;
    else d_req = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_ready", {i_ready, d_ready}, 0);
    chk("idle_strobes", {mem_read, mem_write}, 0);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    m_i_rdata = '0; m_d_rdata = '0; m_prio = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Simultaneous I+D after reset: D first, then a fresh D against pending I.
    i_req = 1'b1; i_addr = 28'h0000030;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 28'h0000040; d_wdata = rand128();
    serve(2, 1'b0, rand128());
    d_req = 1'b1; d_wen = 1'b0; d_addr = 28'h0000050;
    serve(1, 1'b0, rand128());
    serve(3, 1'b0, rand128());

    // I-only read with 4-cycle memory latency.
    i_req = 1'b1; i_addr = 28'h0000010;
    serve(4, 1'b0, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D});

    // D write-back: d_rdata must keep its last refill line.
    d_req = 1'b1; d_wen = 1'b1; d_addr = 28'h0000200;
    d_wdata = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978};
    serve(2, 1'b0, rand128());

    // D request arriving during an I access waits until after i_ready.
    i_req = 1'b1; i_addr = 28'h0000400;
    serve(3, 1'b1, rand128());
    serve(2, 1'b0, rand128());

    // Spurious mem_ready in IDLE.
    mem_ready = 1'b1; mem_rdata = rand128();
    step();
    mem_ready = 1'b0;
    chk("spur_busy", busy, 0);
    chk("spur_ready", {i_ready, d_ready}, 0);
    chk("spur_strobes", {mem_read, mem_write}, 0);
    chk("spur_i_rdata", i_rdata, m_i_rdata);
    chk("spur_d_rdata", d_rdata, m_d_rdata);

    // Reset in ACC_D with no mem_ready.
    d_req = 1'b1; d_wen = 1'b0; d_addr = 28'h0000600;
    step(); step();
    chk("accd_read", mem_read, 1);
    rst = 1'b1;
    step();
    chk("midrst_strobes", {mem_read, mem_write}, 0);
    chk("midrst_d_ready", d_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    rst = 1'b0; d_req = 1'b0;
    m_i_rdata = '0; m_d_rdata = '0; m_prio = 1'b1;
    step();
    chk("postrst_busy", busy, 0);

    // Randomized request mixes; the loser of each round stays pending.
    for (int n = 0; n < 40; n++) begin
      if (!i_req && ($urandom_range(0, 1) == 1)) begin
        i_req = 1'b1; i_addr = rand28();
      end
      if (!d_req && ($urandom_range(0, 1) == 1)) begin
        d_req = 1'b1; d_wen = 1'($urandom_range(0, 1));
        d_addr = rand28(); d_wdata = rand128();
      end
      if (!i_req && !d_req) begin
        i_req = 1'b1; i_addr = rand28();
      end
      serve($urandom_range(1, 5), 1'b0, rand128());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
